byte_addsub_seq: RTL and testbench

BYTE_ADDSUB_SEQ -- requirements
Module: byte_addsub_seq

---
 rtl/byte_addsub_seq.sv | 100 ++++++++++
 tb/tb_byte_addsub_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/byte_addsub_seq.sv
// Byte-serial adder/subtractor that processes one 8-bit slice per cycle, starting with the LSB slice.
// Signed overflow output is built only when ADDSEQ_OVF_EN is defined; otherwise ovf is tied low.
module byte_addsub_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                c_out,
  output logic                ovf
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [W-1:0]     a_q, b_q;
  logic             mode_q;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [7:0]       a_byte, b_byte;
  logic [8:0]       sum;
  logic             last, accept;

  // Subtraction is A + ~B + 1: the slice inverts B and the carry register is seeded with ~mode.
  always_comb begin
    a_byte = a_q[8*idx +: 8];
    b_byte = b_q[8*idx +: 8] ^ {8{~mode_q}};
    sum    = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
    last   = (idx == IDXW'(NBYTES - 1));
    accept = start && (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so all registers see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      idx    <= '0;
      carry  <= ~mode;
      result <= '0;
    end else if (state == RUN) begin
      result[8*idx +: 8] <= sum[7:0];
      carry              <= sum[8];
      idx                <= idx + IDXW'(1);
      if (last) c_out <= sum[8];
    end
  end

`ifdef ADDSEQ_OVF_EN
  // Carry into the MSB is recovered from the sum bit: a7 ^ b7 ^ s7.
  logic ovf_term;
  assign ovf_term = a_byte[7] ^ b_byte[7] ^ sum[7] ^ sum[8];

  always_ff @(posedge clk) begin
    if (rst)                         ovf <= 1'b0;
    else if (state == RUN && last &&
             !accept)                ovf <= ovf_term;
  end
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_byte_addsub_seq.sv
// Self-checking bench for byte_addsub_seq (NBYTES=4): directed cases followed by random operations,
// checked against an arithmetic reference model.
module tb_byte_addsub_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst, start, mode;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] result;

  int tests  = 0;
  int failed = 0;

  byte_addsub_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic, carry/no-borrow, and signed overflow from operand signs.
  task automatic model(input bit m, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [63:0] full;
    if (m) begin
      full = 64'(x) + 64'(y);
      r    = full[W-1:0];
      c    = full[W];
      v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
`ifndef ADDSEQ_OVF_EN
    v = 1'b0;
`endif
  endtask

  // Launches one operation, scrambles inputs during RUN, optionally pokes start in the 2nd RUN cycle,
  // then checks latency, busy length, the one-cycle done pulse and held outputs.
  task automatic run_op(input string tag, input bit m, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit poke);
    logic [W-1:0] r_exp;
    logic         c_exp, v_exp;
    int           n, busy_cnt;
    model(m, x, y, r_exp, c_exp, v_exp);
    start = 1'b1; mode = m; a = x; b = y;
    step();
    start = 1'b0;
    n = 1; busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      start = poke && (n == 2);
      step();
      n++;
    end
    start = 1'b0;
    check({tag, " done_latency"}, 64'(n), 64'(NB + 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(NB));
    check({tag, " result"}, 64'(result), 64'(r_exp));
    check({tag, " c_out"}, 64'(c_out), 64'(c_exp));
    check({tag, " ovf"}, 64'(ovf), 64'(v_exp));
    step();
    check({tag, " done_pulse_len"}, 64'(done), 64'(0));
    step();
    step();
    check({tag, " hold"}, {31'd0, c_out, result}, {31'd0, c_exp, r_exp});
  endtask

  initial begin
    logic [W-1:0] r_exp;
    logic         c_exp, v_exp;
    int           n, seen;

    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    step();
    step();
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset outs", {62'd0, c_out, ovf}, 64'(0));
    check("reset result", 64'(result), 64'(0));
    rst = 1'b0;
    step();

    run_op("add_ff_1",  1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op("sub_0_1",   1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("sub_5_3",   1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    run_op("add_ovf",   1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("add_wrap",  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_ovf",   1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op("start_ign", 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);

    // Reset in the 3rd RUN cycle aborts with no done pulse afterwards.
    start = 1'b1; mode = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0101_0101;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort result", 64'(result), 64'(0));
    check("abort done", 64'(done), 64'(0));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) seen++;
    end
    check("abort no_done", 64'(seen), 64'(0));

    // Reset and start together: start is discarded.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start busy", 64'(busy), 64'(0));
    step();
    check("rst_start idle", 64'(busy), 64'(0));

    // Back-to-back: start held through the DONE cycle with 1+1.
    model(1'b1, 32'hA5A5_0F0F, 32'h5A5A_F0F1, r_exp, c_exp, v_exp);
    start = 1'b1; mode = 1'b1; a = 32'hA5A5_0F0F; b = 32'h5A5A_F0F1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      if (n == NB) begin start = 1'b1; mode = 1'b1; a = 32'd1; b = 32'd1; end
      step();
      n++;
    end
    check("b2b first_latency", 64'(n), 64'(NB + 1));
    check("b2b first_result", 64'(result), 64'(r_exp));
    check("b2b first_cout", 64'(c_out), 64'(c_exp));
    step();
    start = 1'b0;
    check("b2b rerun busy", 64'(busy), 64'(1));
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("b2b second_latency", 64'(n), 64'(NB + 1));
    check("b2b second_result", 64'(result), 64'(2));
    step();

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("rand%0d", i), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
